// File: rtl/b5_seq_divider_if.sv
// b5_seq_divider_if: operand/result handshake bundle for the sequential divider.
// Divider side uses the slave modport; the producer/consumer uses master.
interface b5_seq_divider_if #(
    parameter int unsigned WIDTH = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 dz;
    logic                 ovf;

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, dz, ovf
    );

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, dz, ovf
    );
endinterface

// File: rtl/b5_seq_divider.sv
// b5_seq_divider: sequential restoring divider, 2*WIDTH-bit dividend by
// WIDTH-bit divisor, one quotient bit per cycle MSB first.
// Optional macro B5_DIV_OVF_EN enables the quotient-overflow flag; when it is
// undefined the ovf output is tied low.
module b5_seq_divider #(
    parameter int unsigned WIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    b5_seq_divider_if.slave   bus
);
    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(DW + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

    logic [1:0]       state_q, state_d;
    logic [DW-1:0]    dvd_q,   dvd_d;
    logic [WIDTH-1:0] dvs_q,   dvs_d;
    logic [WIDTH:0]   prem_q,  prem_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [DW-1:0]    quot_q,  quot_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic             dz_q,    dz_d;
`ifdef B5_DIV_OVF_EN
    logic             ovf_q,   ovf_d;
`endif

    logic [WIDTH+1:0] shifted;
    logic             sub_ok;
    logic [WIDTH:0]   prem_step;
    logic [DW-1:0]    dvd_step;

    // One restoring step: shift {prem, dividend} left, trial-subtract divisor.
    always_comb begin
        shifted   = {prem_q, dvd_q[DW-1]};
        sub_ok    = (shifted >= {2'b00, dvs_q});
        if (sub_ok) begin
            prem_step = shifted[WIDTH:0] - {1'b0, dvs_q};
            dvd_step  = {dvd_q[DW-2:0], 1'b1};
        end else begin
            prem_step = shifted[WIDTH:0];
            dvd_step  = {dvd_q[DW-2:0], 1'b0};
        end
    end

    // Next-state and result-register selection for the IDLE/CALC/DONE FSM.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
`ifdef B5_DIV_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dvd_d  = bus.dividend;
                    dvs_d  = bus.divisor;
                    prem_d = '0;
                    cnt_d  = '0;
                    if (bus.divisor == '0) begin
                        // Divide-by-zero skips the iteration entirely.
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = '0;
                        dz_d    = 1'b1;
`ifdef B5_DIV_OVF_EN
                        ovf_d   = 1'b0;
`endif
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                dvd_d  = dvd_step;
                prem_d = prem_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                    quot_d  = dvd_step;
                    rem_d   = prem_step[WIDTH-1:0];
                    dz_d    = 1'b0;
`ifdef B5_DIV_OVF_EN
                    ovf_d   = |dvd_step[DW-1:WIDTH];
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

`ifdef B5_DIV_OVF_EN
    // Overflow flag register: quotient needs more than WIDTH bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    // Handshake flags decode purely from the state register.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.dz        = dz_q;

endmodule
